// File: rtl/encryptor_top.sv
// Niederreiter syndrome encryptor: byte-serial message load, bit-serial XOR of LFSR-generated key columns.
// Latency: done rises 320 edges after the edge that samples start. No backpressure: wr_en/start in RUN are dropped.
// Optional ENC_BUSY_EN adds a busy output that is high while the engine is running.
module encryptor_top #(
   parameter int              MSG_BYTES = 40,
   parameter int              CT_W      = 297,
   parameter logic [CT_W-1:0] SEED      = 297'h1_2345_6789_ABCD_EF01
) (
   input  logic            clk,
   input  logic            rst_b,
   input  logic [7:0]      plaintext,
   input  logic            wr_en,
   input  logic            start,
   output logic [CT_W-1:0] ciphertext,
   output logic            done
`ifdef ENC_BUSY_EN
   ,
   output logic            busy
`endif
);

   localparam int MW = 8 * MSG_BYTES;
   localparam int CW = $clog2(MW);
   localparam int PW = $clog2(MSG_BYTES + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                      state, state_nxt;
   logic [MSG_BYTES-1:0][7:0]   msg;
   logic [MW-1:0]               msg_flat;
   logic [PW-1:0]               wp;
   logic [CW-1:0]               cnt;
   logic [CT_W-1:0]             acc, lfsr;
   logic [CT_W-1:0]             acc_nxt, lfsr_nxt;
   logic [CW-1:0]               bit_idx;
   logic [PW-1:0]               byte_idx;
   logic                        msg_bit, last_bit, launch, wr_ok;

   // Byte p lands at the top of the flat buffer, so it is packed entry MSG_BYTES-1-p.
   assign msg_flat = msg;
   assign bit_idx  = CW'(MW - 1) - cnt;
   assign byte_idx = PW'(MSG_BYTES - 1) - wp;
   assign msg_bit  = msg_flat[bit_idx];

   assign launch   = (state != RUN) && start;
   assign wr_ok    = (state != RUN) && !start && wr_en && (wp != PW'(MSG_BYTES));
   assign last_bit = (state == RUN) && (cnt == CW'(MW - 1));

   assign acc_nxt  = msg_bit ? (acc ^ lfsr) : acc;
   assign lfsr_nxt = {lfsr[CT_W-2:0], lfsr[CT_W-1] ^ lfsr[CT_W-6]};

`ifdef ENC_BUSY_EN
   assign busy = (state == RUN);
`endif

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            if (last_bit) state_nxt = DONE;
         end
         DONE: begin
            if (start)      state_nxt = RUN;
            else if (wr_en) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         acc        <= '0;
         lfsr       <= SEED;
         cnt        <= '0;
         ciphertext <= '0;
         done       <= 1'b0;
      end else if (launch) begin
         acc  <= '0;
         lfsr <= SEED;
         cnt  <= '0;
         done <= 1'b0;
      end else if (state == RUN) begin
         acc  <= acc_nxt;
         lfsr <= lfsr_nxt;
         cnt  <= cnt + 1'b1;
         // acc_nxt already folds in the final message bit.
         if (last_bit) begin
            ciphertext <= acc_nxt;
            done       <= 1'b1;
         end
      end else if (wr_en) begin
         done <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         msg <= '0;
         wp  <= '0;
      end else if (last_bit) begin
         wp <= '0;
      end else if (wr_ok) begin
         msg[byte_idx] <= plaintext;
         wp            <= wp + 1'b1;
      end
   end

endmodule

// File: tb/tb_encryptor_top.sv
// Directed bench for encryptor_top: hand-computed single-column cases plus a reference XOR model for full messages.
module tb_encryptor_top;

   localparam int              CT_W = 297;
   localparam logic [CT_W-1:0] SEED = 297'h1_2345_6789_ABCD_EF01;
   localparam logic [CT_W-1:0] L1   = 297'h2_468A_CF13_579B_DE02;
   localparam logic [CT_W-1:0] S_L1 = 297'h3_65CF_A89A_FC56_3103;

   logic            clk = 1'b0;
   logic            rst_b = 1'b0;
   logic [7:0]      plaintext = 8'h00;
   logic            wr_en = 1'b0;
   logic            start = 1'b0;
   logic [CT_W-1:0] ciphertext;
   logic            done;
`ifdef ENC_BUSY_EN
   logic            busy;
`endif

   int              tests = 0;
   int              fails = 0;
   logic [379:0]    bin_msg;
   logic [319:0]    ref_m;

   encryptor_top dut (
      .clk        (clk),
      .rst_b      (rst_b),
      .plaintext  (plaintext),
      .wr_en      (wr_en),
      .start      (start),
      .ciphertext (ciphertext),
      .done       (done)
`ifdef ENC_BUSY_EN
      ,
      .busy       (busy)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [CT_W-1:0] model_ct(input logic [319:0] m);
      logic [CT_W-1:0] l, a;
      l = SEED;
      a = '0;
      for (int j = 0; j < 320; j++) begin
         if (m[319-j]) a = a ^ l;
         l = {l[CT_W-2:0], l[296] ^ l[291]};
      end
      return a;
   endfunction

   task automatic load_msg(input logic [319:0] m, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (k < 40) plaintext = m[319-8*k -: 8];
         else        plaintext = 8'hFF;
         wr_en = 1'b1;
      end
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic run_wait(output int cyc);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst_b = 1'b0;
      #1;
      tests++;
      if (done !== 1'b0) begin
         fails++; $display("FAIL reset_done: got %b want 0", done);
      end
      tests++;
      if (ciphertext !== '0) begin
         fails++; $display("FAIL reset_ct: got %h want 0", ciphertext);
      end
      @(negedge clk);
      rst_b = 1'b1;
   endtask

   task automatic test_zero_msg();
      int cyc;
      load_msg('0, 40);
      run_wait(cyc);
      tests++;
      if (cyc !== 320) begin
         fails++; $display("FAIL zero_latency: got %0d edges want 320", cyc);
      end
      tests++;
      if (ciphertext !== '0) begin
         fails++; $display("FAIL zero_ct: got %h want 0", ciphertext);
      end
   endtask

   task automatic test_single_bits();
      int cyc;
      load_msg({8'h80, 312'h0}, 40);
      run_wait(cyc);
      tests++;
      if (done !== 1'b1 || ciphertext !== SEED) begin
         fails++; $display("FAIL bit0_ct: got %h done=%b want %h", ciphertext, done, SEED);
      end
      load_msg({8'h40, 312'h0}, 40);
      run_wait(cyc);
      tests++;
      if (done !== 1'b1 || ciphertext !== L1) begin
         fails++; $display("FAIL bit1_ct: got %h done=%b want %h", ciphertext, done, L1);
      end
      load_msg({8'hC0, 312'h0}, 1);
      run_wait(cyc);
      tests++;
      if (done !== 1'b1 || ciphertext !== S_L1) begin
         fails++; $display("FAIL bit01_ct: got %h done=%b want %h", ciphertext, done, S_L1);
      end
   endtask

   task automatic test_ref_msg();
      int cyc;
      logic [CT_W-1:0] exp_ct;
      exp_ct = model_ct(ref_m);
      load_msg(ref_m, 40);
      run_wait(cyc);
      tests++;
      if (cyc !== 320 || ciphertext !== exp_ct) begin
         fails++; $display("FAIL ref_ct: got %h after %0d edges want %h after 320", ciphertext, cyc, exp_ct);
      end
      repeat (7) @(negedge clk);
      tests++;
      if (done !== 1'b1) begin
         fails++; $display("FAIL ref_done_hold: got %b want 1", done);
      end
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (50) @(negedge clk);
      tests++;
      if (done !== 1'b0 || ciphertext !== exp_ct) begin
         fails++; $display("FAIL ref_run_hold: got %h done=%b want %h done=0", ciphertext, done, exp_ct);
      end
      cyc = 50;
      while (done !== 1'b1 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      tests++;
      if (cyc !== 320 || ciphertext !== exp_ct) begin
         fails++; $display("FAIL ref_rerun: got %h after %0d edges want %h after 320", ciphertext, cyc, exp_ct);
      end
   endtask

   task automatic test_overflow();
      int cyc;
      logic [CT_W-1:0] exp_ct;
      exp_ct = model_ct(ref_m);
      @(negedge clk);
      plaintext = ref_m[319:312];
      wr_en = 1'b1;
      @(negedge clk);
      tests++;
      if (done !== 1'b0) begin
         fails++; $display("FAIL wr_clears_done: got %b want 0", done);
      end
      for (int k = 1; k < 41; k++) begin
         if (k < 40) plaintext = ref_m[319-8*k -: 8];
         else        plaintext = 8'hFF;
         @(negedge clk);
      end
      wr_en = 1'b0;
      run_wait(cyc);
      tests++;
      if (done !== 1'b1 || ciphertext !== exp_ct) begin
         fails++; $display("FAIL overflow_ct: got %h done=%b want %h", ciphertext, done, exp_ct);
      end
   endtask

   task automatic test_reset_mid_run();
      int cyc;
      logic [CT_W-1:0] exp_ct;
      exp_ct = model_ct(ref_m);
      load_msg({8'h80, 312'h0}, 40);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (100) @(negedge clk);
      rst_b = 1'b0;
      #1;
      tests++;
      if (done !== 1'b0 || ciphertext !== '0) begin
         fails++; $display("FAIL midrun_reset: got %h done=%b want 0 done=0", ciphertext, done);
      end
      @(negedge clk);
      rst_b = 1'b1;
      load_msg(ref_m, 40);
      run_wait(cyc);
      tests++;
      if (cyc !== 320 || ciphertext !== exp_ct) begin
         fails++; $display("FAIL after_reset_ct: got %h after %0d edges want %h after 320", ciphertext, cyc, exp_ct);
      end
   endtask

   initial begin
      for (int i = 0; i < 380; i++) bin_msg[i] = (((i * 13) + (i / 7)) % 3 == 0);
      ref_m = bin_msg[379:60];
      test_reset();
      test_zero_msg();
      test_single_bits();
      test_ref_msg();
      test_overflow();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
